// File: rtl/bist_lfsr_misr.sv
// bist_lfsr_misr: BIST datapath with a Galois LFSR pattern generator and a MISR response compactor.
// Status outputs are sticky until the next init or reset.
module bist_lfsr_misr #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_POLY = 8'hB8,
    parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
    parameter logic [WIDTH-1:0] MISR_POLY = 8'hB8,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             finish,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_count,
    output logic             sig_valid,
    output logic             pass,
    output logic             fail
);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [WIDTH-1:0] SEED = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_pattern, r_sig;
    logic [CNT_W-1:0] r_count;
    logic             r_sig_valid, r_pass, r_fail;
    logic             w_apply, w_compress, w_compare;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_apply    = (r_state == ACTIVE) && running && !init;
        w_compare  = (r_state == ACTIVE) && finish && !init;
        w_compress = w_apply && !finish;
        w_next     = init ? ACTIVE : w_compare ? DONE : r_state;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset || init) begin
            r_pattern   <= SEED;
            r_sig       <= '0;
            r_count     <= '0;
            r_sig_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            if (w_compress) begin
                r_pattern <= (r_pattern >> 1) ^ (r_pattern[0] ? LFSR_POLY : '0);
                r_sig     <= (r_sig >> 1) ^ (r_sig[0] ? MISR_POLY : '0) ^ cut_resp;
                r_count   <= r_count + ((&r_count) ? CNT_W'(0) : CNT_W'(1));
            end
            if (w_compare) begin
                r_sig_valid <= 1'b1;
                r_pass      <= (r_sig == golden);
                r_fail      <= (r_sig != golden);
            end
        end

    assign pattern       = r_pattern;
    assign pattern_valid = w_apply;
    assign signature     = r_sig;
    assign pattern_count = r_count;
    assign sig_valid     = r_sig_valid;
    assign pass          = r_pass;
    assign fail          = r_fail;

    a_pattern_nonzero: assert property (@(posedge clk) disable iff (reset) r_pattern != '0);
endmodule

// File: tb/tb_bist_lfsr_misr.sv
// tb_bist_lfsr_misr: vector table driven through a scoreboard queue, plus
// hand-written async-reset and count-saturation sequences.
module tb_bist_lfsr_misr;
    logic       clk = 1'b0;
    logic       reset, init, running, finish;
    logic [7:0] golden, cut_resp;
    logic [7:0] pattern, signature, pattern_count;
    logic       pattern_valid, sig_valid, pass, fail;

    int checks = 0;
    int errors = 0;

    bist_lfsr_misr dut (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .golden(golden), .cut_resp(cut_resp), .pattern(pattern),
        .pattern_valid(pattern_valid), .signature(signature),
        .pattern_count(pattern_count), .sig_valid(sig_valid), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       i, r, f;
        logic [7:0] resp, gold;
        logic       pv;
        logic [7:0] pat, sig, cnt;
        logic       sv, ps, fl;
    } vec_t;

    localparam int N = 31;
    vec_t tbl [N];
    vec_t q [$];

    function automatic vec_t v(input logic i, r, f, input logic [7:0] resp, gold,
                               input logic pv, input logic [7:0] pat, sig, cnt,
                               input logic sv, ps, fl);
        v = {i, r, f, resp, gold, pv, pat, sig, cnt, sv, ps, fl};
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] pat, sig, cnt,
                           input logic sv, ps, fl);
        chk({tag, " pattern"}, pattern, pat);
        chk({tag, " signature"}, signature, sig);
        chk({tag, " count"}, pattern_count, cnt);
        chk({tag, " sig_valid"}, {7'b0, sig_valid}, {7'b0, sv});
        chk({tag, " pass"}, {7'b0, pass}, {7'b0, ps});
        chk({tag, " fail"}, {7'b0, fail}, {7'b0, fl});
    endtask

    initial begin
        vec_t e;
        //            i  r  f  resp   gold   pv pat    sig    cnt   sv ps fl
        tbl[0]  = v(0, 1, 1, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[2]  = v(0, 1, 0, 8'h00, 8'h00, 1, 8'hB8, 8'h00, 8'd1, 0, 0, 0);
        tbl[3]  = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h5C, 8'h00, 8'd2, 0, 0, 0);
        tbl[4]  = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h2E, 8'h00, 8'd3, 0, 0, 0);
        tbl[5]  = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h17, 8'h00, 8'd4, 0, 0, 0);
        tbl[6]  = v(0, 1, 0, 8'h00, 8'h00, 1, 8'hB3, 8'h00, 8'd5, 0, 0, 0);
        tbl[7]  = v(0, 0, 0, 8'h00, 8'h00, 0, 8'hB3, 8'h00, 8'd5, 0, 0, 0);
        tbl[8]  = v(0, 0, 1, 8'h00, 8'h00, 0, 8'hB3, 8'h00, 8'd5, 1, 1, 0);
        tbl[9]  = v(0, 1, 1, 8'h33, 8'hFF, 0, 8'hB3, 8'h00, 8'd5, 1, 1, 0);
        tbl[10] = v(1, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[11] = v(0, 1, 0, 8'h01, 8'h00, 1, 8'hB8, 8'h01, 8'd1, 0, 0, 0);
        tbl[12] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h5C, 8'hB8, 8'd2, 0, 0, 0);
        tbl[13] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h2E, 8'h5C, 8'd3, 0, 0, 0);
        tbl[14] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h17, 8'h2E, 8'd4, 0, 0, 0);
        tbl[15] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'hB3, 8'h17, 8'd5, 0, 0, 0);
        tbl[16] = v(0, 0, 1, 8'h00, 8'h17, 0, 8'hB3, 8'h17, 8'd5, 1, 1, 0);
        tbl[17] = v(1, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[18] = v(0, 1, 0, 8'h01, 8'h00, 1, 8'hB8, 8'h01, 8'd1, 0, 0, 0);
        tbl[19] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h5C, 8'hB8, 8'd2, 0, 0, 0);
        tbl[20] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h2E, 8'h5C, 8'd3, 0, 0, 0);
        tbl[21] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h17, 8'h2E, 8'd4, 0, 0, 0);
        tbl[22] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'hB3, 8'h17, 8'd5, 0, 0, 0);
        tbl[23] = v(0, 0, 1, 8'h00, 8'h18, 0, 8'hB3, 8'h17, 8'd5, 1, 0, 1);
        tbl[24] = v(1, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[25] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'hB8, 8'h00, 8'd1, 0, 0, 0);
        tbl[26] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h5C, 8'h00, 8'd2, 0, 0, 0);
        tbl[27] = v(0, 1, 0, 8'h00, 8'h00, 1, 8'h2E, 8'h00, 8'd3, 0, 0, 0);
        tbl[28] = v(1, 1, 1, 8'h77, 8'h00, 0, 8'h01, 8'h00, 8'd0, 0, 0, 0);
        tbl[29] = v(0, 1, 0, 8'h5A, 8'h00, 1, 8'hB8, 8'h5A, 8'd1, 0, 0, 0);
        tbl[30] = v(0, 1, 1, 8'hFF, 8'h5A, 1, 8'hB8, 8'h5A, 8'd1, 1, 1, 0);

        reset = 1'b1; init = 1'b0; running = 1'b0; finish = 1'b0;
        golden = 8'h00; cut_resp = 8'h00;
        @(posedge clk); #1;
        chk_all("reset", 8'h01, 8'h00, 8'd0, 0, 0, 0);
        @(negedge clk) reset = 1'b0;

        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            init = tbl[k].i; running = tbl[k].r; finish = tbl[k].f;
            cut_resp = tbl[k].resp; golden = tbl[k].gold;
            q.push_back(tbl[k]);
            #1 chk($sformatf("v%0d pattern_valid", k), {7'b0, pattern_valid}, {7'b0, tbl[k].pv});
            @(posedge clk); #1;
            e = q.pop_front();
            chk_all($sformatf("v%0d", k), e.pat, e.sig, e.cnt, e.sv, e.ps, e.fl);
        end

        // In DONE with pass=1: reset must clear outputs before any clock edge.
        @(negedge clk);
        init = 1'b0; running = 1'b0; finish = 1'b0;
        reset = 1'b1;
        #1 chk_all("async_reset", 8'h01, 8'h00, 8'd0, 0, 0, 0);
        @(negedge clk) reset = 1'b0;

        // Count saturates at 255 and does not wrap.
        init = 1'b1;
        @(negedge clk);
        init = 1'b0; running = 1'b1; cut_resp = 8'h00;
        for (int k = 0; k < 260; k++) @(negedge clk);
        running = 1'b0;
        chk("saturate count", pattern_count, 8'hFF);
        chk("saturate signature", signature, 8'h00);
        @(negedge clk);
        chk("saturate hold", pattern_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
